decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter PC_W, default 12, meaning width of the PC field carried with each instruction.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, meaning reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1, meaning the fetch side presents a valid {in_pc, in_instr}.
REQ-005 SHALL have port in_pc, input, PC_W, meaning the PC of the presented instruction.
REQ-006 SHALL have port in_instr, input, 32, meaning the RV32I instruction word.
REQ-007 SHALL have port in_ready, output, 1, meaning decode can accept an instruction this cycle.
REQ-008 SHALL have port flush, input, 1, meaning discard all held instructions.
REQ-009 SHALL have port out_valid, output, 1, and port out_ready, input, 1, meaning the downstream handshake.
REQ-010 SHALL have ports out_pc (PC_W), out_opclass (4), out_rd (5), out_rs1 (5), out_rs2 (5), out_imm (32), out_illegal (1), all outputs, meaning the decoded instruction.

Function
REQ-011 SHALL transfer in when in_valid && in_ready, and transfer out when out_valid && out_ready.
REQ-012 SHALL hold at most two entries, main and skid, in states EMPTY, ONE, TWO; order is strict FIFO.
REQ-013 SHALL drive in_ready = (state != TWO) from a register, with no combinational path from out_ready.
REQ-014 SHALL make an accepted instruction visible on out_* one cycle after acceptance (latency 1) when the block was EMPTY.
REQ-015 SHALL transition: EMPTY+in -> ONE; ONE+in without out -> TWO; ONE+out without in -> EMPTY; ONE+in+out -> ONE; TWO+out -> ONE, skid moves to main; TWO ignores in_valid.
REQ-016 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-017 SHALL decode opcode[6:0] to out_opclass: 0110111=1 LUI, 0010111=2 AUIPC, 1101111=3 JAL, 1100111=4 JALR, 1100011=5 BRANCH, 0000011=6 LOAD, 0100011=7 STORE, 0010011=8 OPIMM, 0110011=9 OP, 1110011=10 SYSTEM, anything else=0.
REQ-018 SHALL form out_imm sign-extended to 32 bits: I-type (JALR, LOAD, OPIMM, SYSTEM) from [31:20]; S from {[31:25],[11:7]}; B from {[31],[7],[30:25],[11:8],0}; U as {[31:12],12'b0}; J from {[31],[19:12],[20],[30:21],0}; OP and class 0 give 0.
REQ-019 SHALL force out_rd=0 for BRANCH/STORE, out_rs1=0 for LUI/AUIPC/JAL, and out_rs2=0 unless OP/STORE/BRANCH; otherwise take the raw fields [11:7], [19:15], [24:20].
REQ-020 SHALL decode at acceptance time and store the decoded fields, not the raw word.
REQ-021 SHALL, on flush, go to EMPTY next cycle, drop any same-cycle input and output transfer, and leave in_ready=1 after.

Reset
REQ-022 SHALL on rst set state EMPTY, out_valid=0, in_ready=1, and all out_* data fields to 0.
REQ-023 SHALL give rst priority over flush and both handshakes, including while in state TWO.

Configuration
REQ-024 SHALL, with ILLEGAL_DETECT_EN defined, set out_illegal=1 for opclass 0, for an unsupported funct3 (LOAD 3/6/7, STORE >2, BRANCH 2/3, JALR !=0), and for in_instr[1:0]!=2'b11.
REQ-025 SHALL, without ILLEGAL_DETECT_EN, keep the out_illegal port and tie it to 0.

Verification
REQ-026 SHALL cover: in 0x00500093 @pc 0x004, out_ready=1 -> next cycle out_valid=1, opclass 8, rd 1, rs1 0, rs2 0, imm 0x00000005, pc 0x004.
REQ-027 SHALL cover: in 0xFE208EE3 -> opclass 5, rd 0, rs1 1, rs2 2, imm 0xFFFFFFFC.
REQ-028 SHALL cover: out_ready=0, pcs 0x0/0x4/0x8 offered back-to-back -> two accepted, in_ready=0, pc 0x8 held; out_ready=1 -> outputs 0x0, 0x4, 0x8 in order, with no loss or duplication.
REQ-029 SHALL cover: state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0 and in_ready=1, with the input dropped.
REQ-030 SHALL cover: in 0xFFFFFFFF -> opclass 0, imm 0, out_illegal=1 with ILLEGAL_DETECT_EN and 0 without.
REQ-031 SHALL cover: rst asserted in state TWO -> next cycle out_valid=0, in_ready=1, all out_* data 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: two-entry skid buffer (main + skid) holding pre-decoded instructions.
// Define ILLEGAL_DETECT_EN to enable out_illegal detection; otherwise out_illegal is tied to 0.
module decode_stage #(
    parameter int PC_W = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [PC_W-1:0] in_pc,
    input  logic [31:0]     in_instr,
    output logic            in_ready,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [3:0]      out_opclass,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [31:0]     out_imm,
    output logic            out_illegal
);

    localparam logic [3:0] OPC_NONE   = 4'd0;
    localparam logic [3:0] OPC_LUI    = 4'd1;
    localparam logic [3:0] OPC_AUIPC  = 4'd2;
    localparam logic [3:0] OPC_JAL    = 4'd3;
    localparam logic [3:0] OPC_JALR   = 4'd4;
    localparam logic [3:0] OPC_BRANCH = 4'd5;
    localparam logic [3:0] OPC_LOAD   = 4'd6;
    localparam logic [3:0] OPC_STORE  = 4'd7;
    localparam logic [3:0] OPC_OPIMM  = 4'd8;
    localparam logic [3:0] OPC_OP     = 4'd9;
    localparam logic [3:0] OPC_SYSTEM = 4'd10;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [3:0]      opclass;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   in_ready_q, in_ready_d;
    entry_t dec;
    logic   in_fire;
    logic   out_fire;
    logic [2:0] funct3;

    assign funct3 = in_instr[14:12];

    // Decode happens on the incoming word so that only decoded fields are stored.
    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        case (in_instr[6:0])
            7'b0110111: dec.opclass = OPC_LUI;
            7'b0010111: dec.opclass = OPC_AUIPC;
            7'b1101111: dec.opclass = OPC_JAL;
            7'b1100111: dec.opclass = OPC_JALR;
            7'b1100011: dec.opclass = OPC_BRANCH;
            7'b0000011: dec.opclass = OPC_LOAD;
            7'b0100011: dec.opclass = OPC_STORE;
            7'b0010011: dec.opclass = OPC_OPIMM;
            7'b0110011: dec.opclass = OPC_OP;
            7'b1110011: dec.opclass = OPC_SYSTEM;
            default:    dec.opclass = OPC_NONE;
        endcase

        case (dec.opclass)
            OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_SYSTEM:
                dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            OPC_STORE:
                dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            OPC_BRANCH:
                dec.imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                dec.imm = {in_instr[31:12], 12'b0};
            OPC_JAL:
                dec.imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
            default:
                dec.imm = '0;
        endcase

        dec.rd  = (dec.opclass == OPC_BRANCH || dec.opclass == OPC_STORE) ? 5'd0 : in_instr[11:7];
        dec.rs1 = (dec.opclass == OPC_LUI || dec.opclass == OPC_AUIPC || dec.opclass == OPC_JAL)
                  ? 5'd0 : in_instr[19:15];
        dec.rs2 = (dec.opclass == OPC_OP || dec.opclass == OPC_STORE || dec.opclass == OPC_BRANCH)
                  ? in_instr[24:20] : 5'd0;

`ifdef ILLEGAL_DETECT_EN
        dec.illegal = (dec.opclass == OPC_NONE) || (in_instr[1:0] != 2'b11) ||
                      (dec.opclass == OPC_LOAD && (funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7)) ||
                      (dec.opclass == OPC_STORE && funct3 > 3'd2) ||
                      (dec.opclass == OPC_BRANCH && (funct3 == 3'd2 || funct3 == 3'd3)) ||
                      (dec.opclass == OPC_JALR && funct3 != 3'd0);
`else
        dec.illegal = 1'b0;
`endif
    end

    assign out_valid = (state_q != EMPTY);
    assign in_ready  = in_ready_q;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        in_fire  = in_valid && in_ready_q;
        out_fire = out_valid && out_ready;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (in_fire) begin
                    main_d  = dec;
                    state_d = ONE;
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = dec;
                    end else if (in_fire) begin
                        skid_d  = dec;
                        state_d = TWO;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                TWO: if (out_fire) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
        in_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign out_pc      = main_q.pc;
    assign out_opclass = main_q.opclass;
    assign out_rd      = main_q.rd;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_imm     = main_q.imm;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [11:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [11:0] out_pc;
    logic [3:0]  out_opclass;
    logic [4:0]  out_rd, out_rs1, out_rs2;
    logic [31:0] out_imm;
    logic        out_illegal;

    decode_stage #(.PC_W(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_instr(in_instr),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opclass(out_opclass), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned pc;
        int unsigned opclass;
        int unsigned rd, rs1, rs2;
        int unsigned imm;
        int unsigned illegal;
    } ref_t;

    ref_t        model[$];
    int unsigned seen_pc[$];
    bit          zero_expected = 1'b0;
    int          total = 0;
    int          bad = 0;

`ifdef ILLEGAL_DETECT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned sext(input int unsigned raw, input int unsigned bits);
        int unsigned half = 1 << (bits - 1);
        if (raw >= half) return raw - (half * 2);
        return raw;
    endfunction

    function automatic int unsigned fld(input logic [31:0] w, input int unsigned lo, input int unsigned n);
        return (w >> lo) & ((1 << n) - 1);
    endfunction

    function automatic ref_t ref_decode(input logic [11:0] pc, input logic [31:0] w);
        ref_t r;
        int unsigned op = fld(w, 0, 7);
        int unsigned f3 = fld(w, 12, 3);
        int unsigned c;
        case (op)
            'h37: c = 1;  'h17: c = 2;  'h6F: c = 3;  'h67: c = 4;  'h63: c = 5;
            'h03: c = 6;  'h23: c = 7;  'h13: c = 8;  'h33: c = 9;  'h73: c = 10;
            default: c = 0;
        endcase
        r.pc      = pc;
        r.opclass = c;
        case (c)
            4, 6, 8, 10: r.imm = sext(fld(w, 20, 12), 12);
            7:           r.imm = sext(fld(w, 25, 7) * 32 + fld(w, 7, 5), 12);
            5:           r.imm = sext(fld(w, 31, 1) * 4096 + fld(w, 7, 1) * 2048 +
                                      fld(w, 25, 6) * 32 + fld(w, 8, 4) * 2, 13);
            1, 2:        r.imm = fld(w, 12, 20) * 4096;
            3:           r.imm = sext(fld(w, 31, 1) * (1 << 20) + fld(w, 12, 8) * 4096 +
                                      fld(w, 20, 1) * 2048 + fld(w, 21, 10) * 2, 21);
            default:     r.imm = 0;
        endcase
        r.rd  = (c == 5 || c == 7) ? 0 : fld(w, 7, 5);
        r.rs1 = (c >= 1 && c <= 3) ? 0 : fld(w, 15, 5);
        r.rs2 = (c == 9 || c == 7 || c == 5) ? fld(w, 20, 5) : 0;
        r.illegal = (ILL_EN && (c == 0 || fld(w, 0, 2) != 3 ||
                     (c == 6 && (f3 == 3 || f3 == 6 || f3 == 7)) ||
                     (c == 7 && f3 > 2) || (c == 5 && (f3 == 2 || f3 == 3)) ||
                     (c == 4 && f3 != 0))) ? 1 : 0;
        return r;
    endfunction

    task automatic compare_outputs();
        check("out_valid", 32'(out_valid), (model.size() > 0) ? 32'd1 : 32'd0);
        check("in_ready", 32'(in_ready), (model.size() < 2) ? 32'd1 : 32'd0);
        if (model.size() > 0) begin
            check("pc", 32'(out_pc), model[0].pc);
            check("opclass", 32'(out_opclass), model[0].opclass);
            check("rd", 32'(out_rd), model[0].rd);
            check("rs1", 32'(out_rs1), model[0].rs1);
            check("rs2", 32'(out_rs2), model[0].rs2);
            check("imm", out_imm, model[0].imm);
            check("illegal", 32'(out_illegal), model[0].illegal);
        end else if (zero_expected) begin
            check("rst_data", {out_pc, out_opclass, out_rd, out_rs1, out_rs2, out_illegal}, 32'd0);
            check("rst_imm", out_imm, 32'd0);
        end
    endtask

    // One clock: drive at negedge, advance the model at posedge, compare at next negedge.
    task automatic cycle(input logic v, input logic [11:0] pc, input logic [31:0] w,
                         input logic ordy, input logic fl, input logic r);
        bit do_in, do_out;
        in_valid = v; in_pc = pc; in_instr = w; out_ready = ordy; flush = fl; rst = r;
        do_in  = v && (model.size() < 2);
        do_out = ordy && (model.size() > 0);
        if (do_out && !fl && !r) seen_pc.push_back(32'(out_pc));
        @(posedge clk);
        if (r) begin
            model.delete();
            zero_expected = 1'b1;
        end else if (fl) begin
            model.delete();
        end else begin
            if (do_out) void'(model.pop_front());
            if (do_in) begin
                model.push_back(ref_decode(pc, w));
                zero_expected = 1'b0;
            end
        end
        @(negedge clk);
        compare_outputs();
    endtask

    function automatic logic [31:0] gen_instr();
        int unsigned ops[10] = '{'h37, 'h17, 'h6F, 'h67, 'h63, 'h03, 'h23, 'h13, 'h33, 'h73};
        logic [31:0] w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = 7'(ops[$urandom_range(0, 9)]);
        return w;
    endfunction

    initial begin
        @(negedge clk);
        cycle(1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // addi x1, x0, 5
        cycle(1'b1, 12'h004, 32'h00500093, 1'b1, 1'b0, 1'b0);
        check("addi_valid", 32'(out_valid), 32'd1);
        check("addi_opclass", 32'(out_opclass), 32'd8);
        check("addi_rd", 32'(out_rd), 32'd1);
        check("addi_rs1", 32'(out_rs1), 32'd0);
        check("addi_rs2", 32'(out_rs2), 32'd0);
        check("addi_imm", out_imm, 32'h00000005);
        check("addi_pc", 32'(out_pc), 32'h004);

        // beq x1, x2, -4 accepted while the addi leaves
        cycle(1'b1, 12'h008, 32'hFE208EE3, 1'b1, 1'b0, 1'b0);
        check("beq_opclass", 32'(out_opclass), 32'd5);
        check("beq_rd", 32'(out_rd), 32'd0);
        check("beq_rs1", 32'(out_rs1), 32'd1);
        check("beq_rs2", 32'(out_rs2), 32'd2);
        check("beq_imm", out_imm, 32'hFFFFFFFC);
        cycle(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // back-pressure ordering
        seen_pc.delete();
        cycle(1'b1, 12'h000, 32'h00100093, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 12'h004, 32'h00200093, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 12'h008, 32'h00300093, 1'b0, 1'b0, 1'b0);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head_pc", 32'(out_pc), 32'h000);
        cycle(1'b1, 12'h008, 32'h00300093, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 12'h008, 32'h00300093, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("bp_count", seen_pc.size(), 32'd3);
        for (int i = 0; i < 3 && i < seen_pc.size(); i++)
            check("bp_order", seen_pc[i], 32'(i * 4));

        // flush from TWO with a same-cycle input
        cycle(1'b1, 12'h010, 32'h00000013, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 12'h014, 32'h00000013, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 12'h018, 32'h00000013, 1'b1, 1'b1, 1'b0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b0, 12'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("flush_dropped", 32'(out_valid), 32'd0);

        // all-ones word
        cycle(1'b1, 12'h020, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        check("ones_opclass", 32'(out_opclass), 32'd0);
        check("ones_imm", out_imm, 32'd0);
        check("ones_illegal", 32'(out_illegal), 32'(ILL_EN));

        // reset while TWO
        cycle(1'b1, 12'h024, 32'h00500093, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 12'h028, 32'h00500093, 1'b1, 1'b1, 1'b1);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_in_ready", 32'(in_ready), 32'd1);
        check("rst2_imm", out_imm, 32'd0);
        check("rst2_pc", 32'(out_pc), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, 12'($urandom), gen_instr(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
